// File: rtl/vedic_mult_pkg.sv
// Shared definitions for the sequential Vedic nibble multiplier.
// The optional VEDIC_SIGNED_EN macro, consumed by the top level, selects two's-complement operands.
package vedic_mult_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned PP_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Number of nibbles in an operand of the given width
  function automatic int unsigned ndig(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/vedic_nibble_mult.sv
// Combinational 4x4 -> 8 unsigned multiplier (Urdhva-Tiryagbhyam).
// It is built from four 2x2 vertical-crosswise blocks whose partial products are
// recombined by shifted addition.
module vedic_nibble_mult
  import vedic_mult_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [PP_W-1:0]     p
);

  // 2x2 Vedic block: vertical, crosswise, vertical with carry ripple
  function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    logic       c1;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1   = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c1;
    r[3] = (x[1] & y[1]) & c1;
    return r;
  endfunction

  logic [3:0] ll, lh, hl, hh;
  logic [4:0] mid;

  // Combine the four 2x2 products: hh<<4 + (lh+hl)<<2 + ll
  always_comb begin
    ll  = v2(a[1:0], b[1:0]);
    lh  = v2(a[1:0], b[3:2]);
    hl  = v2(a[3:2], b[1:0]);
    hh  = v2(a[3:2], b[3:2]);
    mid = {1'b0, lh} + {1'b0, hl};
    p   = {hh, ll} + {1'b0, mid, 2'b00};
  end

endmodule

// File: rtl/vedic_seq_nibble_mult.sv
// Iterative WIDTH x WIDTH multiplier sequencing one nibble pair per cycle
// through a single 4x4 Vedic core, shift-accumulating into a 2*WIDTH product.
// Valid/ready handshakes on both sides. Defining VEDIC_SIGNED_EN makes
// a, b and product two's complement (magnitudes through the unsigned core).
module vedic_seq_nibble_mult
  import vedic_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned NDIG = ndig(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam logic [1:0]  LAST = 2'(NDIG - 1);

  state_t                state;
  logic [WIDTH-1:0]      a_reg, b_reg;
  logic [1:0]            i, j;
  logic [PW-1:0]         acc, acc_next, pp_ext, result;
  logic [NIBBLE_W-1:0]   a_nib, b_nib;
  logic [PP_W-1:0]       pp;
  logic [4:0]            shamt;
  logic                  last_step;
  logic [WIDTH-1:0]      a_in, b_in;
`ifdef VEDIC_SIGNED_EN
  logic                  neg;
`endif

  vedic_nibble_mult u_core (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  // Select the current nibble pair and form the shifted accumulation
  always_comb begin
    a_nib     = a_reg[NIBBLE_W*i +: NIBBLE_W];
    b_nib     = b_reg[NIBBLE_W*j +: NIBBLE_W];
    shamt     = {({1'b0, i} + {1'b0, j}), 2'b00};
    pp_ext    = PW'(pp) << shamt;
    acc_next  = acc + pp_ext;
    last_step = (i == LAST) && (j == LAST);
  end

  // Operand conditioning and final result formation
  always_comb begin
`ifdef VEDIC_SIGNED_EN
    a_in   = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_in   = b[WIDTH-1] ? (~b + 1'b1) : b;
    result = neg ? (~acc_next + 1'b1) : acc_next;
`else
    a_in   = a;
    b_in   = b;
    result = acc_next;
`endif
  end

  // Control FSM, digit counters, accumulator and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      i         <= '0;
      j         <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
`ifdef VEDIC_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_reg    <= a_in;
            b_reg    <= b_in;
`ifdef VEDIC_SIGNED_EN
            neg      <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (j == LAST) begin
            j <= '0;
            i <= i + 2'd1;
          end else begin
            j <= j + 2'd1;
          end
          if (last_step) begin
            product   <= result;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_nibble_mult.sv
// Directed self-checking bench for vedic_seq_nibble_mult.
// Default build exercises the unsigned WIDTH=8 part; with VEDIC_SIGNED_EN
// the signed WIDTH=16 vectors run instead.
module tb_vedic_seq_nibble_mult;

`ifdef VEDIC_SIGNED_EN
  localparam int unsigned W = 16;
`else
  localparam int unsigned W = 8;
`endif

  logic             clk;
  logic             rst;
  logic [W-1:0]     a, b;
  logic             in_valid, in_ready;
  logic [2*W-1:0]   product;
  logic             out_valid, out_ready, busy;

  int nvec = 0;
  int nmis = 0;

  vedic_seq_nibble_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait (bounded) for in_ready, then take the accept edge
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    n = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    nvec++;
    if (in_ready !== 1'b1) begin
      nmis++;
      $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a = '0;
    b = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #12;
    nvec++; if (in_ready !== 1'b0) begin nmis++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL rst_busy: got %b required 0", busy); end
    nvec++; if (product !== '0) begin nmis++; $display("FAIL rst_product: got %h required 0", product); end
    rst = 1'b0;
    tick;
    nvec++; if (in_ready !== 1'b1) begin nmis++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
  endtask

`ifndef VEDIC_SIGNED_EN
  task automatic test_max_operands;
    int lat;
    out_ready = 1'b1;
    issue(8'hFF, 8'hFF);
    nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL max_busy: got %b required 1", busy); end
    nvec++; if (in_ready !== 1'b0) begin nmis++; $display("FAIL max_ready_calc: got %b required 0", in_ready); end
    wait_done(lat);
    nvec++; if (lat != 4) begin nmis++; $display("FAIL max_latency: got %0d required 4", lat); end
    nvec++; if (product !== 16'hFE01) begin nmis++; $display("FAIL max_product: got %h required fe01", product); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL max_busy_done: got %b required 0", busy); end
    tick;
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL max_one_cycle: out_valid=%b required 0", out_valid); end
    nvec++; if (product !== 16'hFE01) begin nmis++; $display("FAIL max_product_hold: got %h required fe01", product); end
  endtask

  task automatic test_zero_operand;
    int lat;
    out_ready = 1'b1;
    issue(8'h00, 8'hA5);
    wait_done(lat);
    nvec++; if (lat != 4) begin nmis++; $display("FAIL zero_latency: got %0d required 4", lat); end
    nvec++; if (product !== 16'h0000) begin nmis++; $display("FAIL zero_product: got %h required 0000", product); end
    tick;
  endtask

  task automatic test_stall;
    int lat;
    out_ready = 1'b0;
    issue(8'h12, 8'h34);
    wait_done(lat);
    nvec++; if (lat != 4) begin nmis++; $display("FAIL stall_latency: got %0d required 4", lat); end
    for (int k = 0; k < 10; k++) begin
      a = 8'h55 + 8'(k);
      b = 8'h66;
      in_valid = k[0];
      tick;
      nvec++; if (out_valid !== 1'b1) begin nmis++; $display("FAIL stall_valid[%0d]: got %b required 1", k, out_valid); end
      nvec++; if (product !== 16'h03A8) begin nmis++; $display("FAIL stall_product[%0d]: got %h required 03a8", k, product); end
      nvec++; if (in_ready !== 1'b0) begin nmis++; $display("FAIL stall_ready[%0d]: got %b required 0", k, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL stall_release: out_valid=%b required 0", out_valid); end
    nvec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin nmis++; $display("FAIL stall_idle: in_ready=%b busy=%b required 1/0", in_ready, busy); end
  endtask

  task automatic test_reset_mid_calc;
    int lat;
    out_ready = 1'b1;
    issue(8'h77, 8'h99);
    tick;
    #2 rst = 1'b1;
    #1;
    nvec++; if (product !== 16'h0000) begin nmis++; $display("FAIL midrst_product: got %h required 0000", product); end
    nvec++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      nmis++; $display("FAIL midrst_flags: busy=%b out_valid=%b in_ready=%b required 0/0/0", busy, out_valid, in_ready);
    end
    tick;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL midrst_no_valid[%0d]: got %b required 0", k, out_valid); end
    end
    issue(8'h0F, 8'h11);
    wait_done(lat);
    nvec++; if (lat != 4) begin nmis++; $display("FAIL midrst_latency: got %0d required 4", lat); end
    nvec++; if (product !== 16'h00FF) begin nmis++; $display("FAIL midrst_product_next: got %h required 00ff", product); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] ea, eb, ex;
    int accepted, got, cyc;
    logic take;
    accepted = 0;
    got = 0;
    cyc = 0;
    out_ready = 1'b1;
    a = W'($urandom);
    b = W'($urandom);
    in_valid = 1'b1;
    while (got < 100 && cyc < 2000) begin
      if (out_valid === 1'b1) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nmis++; $display("FAIL b2b_spurious: product=%h with no op outstanding", product);
        end else begin
          ex = exp_q.pop_front();
          if (product !== ex) begin nmis++; $display("FAIL b2b_product[%0d]: got %h required %h", got, product, ex); end
        end
        got++;
      end
      if (in_ready === 1'b1 && (busy === 1'b1 || out_valid === 1'b1)) begin
        nvec++; nmis++;
        $display("FAIL b2b_ready_excl: in_ready=1 busy=%b out_valid=%b required ready only in idle", busy, out_valid);
      end
      take = (in_ready === 1'b1) && (accepted < 100);
      if (take) begin
        ea = (2*W)'(a);
        eb = (2*W)'(b);
        exp_q.push_back(ea * eb);
        accepted++;
      end
      tick;
      cyc++;
      if (take) begin
        a = W'($urandom);
        b = W'($urandom);
        if (accepted >= 100) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    nvec++; if (got != 100) begin nmis++; $display("FAIL b2b_count: got %0d results required 100", got); end
  endtask
`else
  task automatic test_signed;
    int lat;
    out_ready = 1'b1;
    issue(16'h8000, 16'h8000);
    wait_done(lat);
    nvec++; if (lat != 16) begin nmis++; $display("FAIL sgn_latency: got %0d required 16", lat); end
    nvec++; if (product !== 32'h40000000) begin nmis++; $display("FAIL sgn_minmin: got %h required 40000000", product); end
    tick;
    issue(16'hFFFD, 16'h0007);
    wait_done(lat);
    nvec++; if (lat != 16) begin nmis++; $display("FAIL sgn_latency2: got %0d required 16", lat); end
    nvec++; if (product !== 32'hFFFFFFEB) begin nmis++; $display("FAIL sgn_m3x7: got %h required ffffffeb", product); end
    tick;
    issue(16'h0064, 16'hFF38);
    wait_done(lat);
    nvec++; if (product !== 32'hFFFFB1E0) begin nmis++; $display("FAIL sgn_100xm200: got %h required ffffb1e0", product); end
    tick;
    issue(16'h7FFF, 16'h7FFF);
    wait_done(lat);
    nvec++; if (product !== 32'h3FFF0001) begin nmis++; $display("FAIL sgn_maxmax: got %h required 3fff0001", product); end
    tick;
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL sgn_one_cycle: out_valid=%b required 0", out_valid); end
  endtask
`endif

  initial begin
    test_reset;
`ifndef VEDIC_SIGNED_EN
    test_max_operands;
    test_zero_operand;
    test_stall;
    test_reset_mid_calc;
    test_back_to_back;
`else
    test_signed;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
